// File: rtl/segswap_pkg.sv
// Shared types for the segment swapper.
//   swap_mode_e : per-beat transform selector (matches the 2-bit in_mode encoding)
//   occ_e       : occupancy of the main/skid register pair
package segswap_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_PAIR    = 2'b01,
    MODE_REV_SEG = 2'b10,
    MODE_REV_BIT = 2'b11
  } swap_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,  // main register empty
    OCC_ONE   = 2'b01,  // main full, skid empty
    OCC_TWO   = 2'b10   // main and skid full
  } occ_e;

endpackage

// File: rtl/segswap_xform.sv
// Purely combinational segment transform.
// Ports:
//   data_i : input word (DATA_W bits)
//   mode_i : transform selector (swap_mode_e)
//   data_o : transformed word (DATA_W bits)
// Segment i occupies bits [i*SEG_W +: SEG_W].
module segswap_xform
  import segswap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEG_W  = 4
) (
  input  logic [DATA_W-1:0] data_i,
  input  swap_mode_e        mode_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int N = DATA_W / SEG_W;

  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_PASS: data_o = data_i;
      MODE_PAIR: begin
        // i^1 pairs segment 2k with 2k+1
        for (int i = 0; i < N; i++)
          data_o[i*SEG_W +: SEG_W] = data_i[(i ^ 1)*SEG_W +: SEG_W];
      end
      MODE_REV_SEG: begin
        for (int i = 0; i < N; i++)
          data_o[i*SEG_W +: SEG_W] = data_i[(N-1-i)*SEG_W +: SEG_W];
      end
      MODE_REV_BIT: begin
        for (int i = 0; i < DATA_W; i++)
          data_o[i] = data_i[DATA_W-1-i];
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/segment_swapper.sv
// Registered segment swapper with a 2-entry skid buffer (main M + skid S).
// One cycle latency, full throughput under valid/ready backpressure.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : producer handshake (in_ready is registered)
//   in_data, in_mode      : input word and per-beat transform mode
//   out_valid/out_ready   : consumer handshake
//   out_data              : transformed word, held stable until transferred
//   swap_count            : saturating count of transferred beats with mode != 00
// Optional feature macro: SEGSWAP_STATS_EN (adds swap_count and carried mode bits).
module segment_swapper
  import segswap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef SEGSWAP_STATS_EN
  ,
  output logic [CNT_W-1:0]  swap_count
`endif
);

  if ((DATA_W % (2 * SEG_W)) != 0 || SEG_W < 1) begin : g_bad_width
    $error("segment_swapper: DATA_W must be a multiple of 2*SEG_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("segment_swapper: CNT_W must be at least 1");
  end

  occ_e              state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [DATA_W-1:0] xf_data;
  logic              accept, drain;

  segswap_xform #(.DATA_W(DATA_W), .SEG_W(SEG_W)) u_xform (
    .data_i (in_data),
    .mode_i (swap_mode_e'(in_mode)),
    .data_o (xf_data)
  );

  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = m_data_q;
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

`ifdef SEGSWAP_STATS_EN
  swap_mode_e        m_mode_q, m_mode_d;
  swap_mode_e        s_mode_q, s_mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign swap_count = cnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
`ifdef SEGSWAP_STATS_EN
    m_mode_d = m_mode_q;
    s_mode_d = s_mode_q;
`endif
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d  = OCC_ONE;
          m_data_d = xf_data;
`ifdef SEGSWAP_STATS_EN
          m_mode_d = swap_mode_e'(in_mode);
`endif
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          m_data_d = xf_data;
`ifdef SEGSWAP_STATS_EN
          m_mode_d = swap_mode_e'(in_mode);
`endif
        end else if (accept) begin
          // M is stalled; park the new beat in the skid register
          state_d  = OCC_TWO;
          s_data_d = xf_data;
`ifdef SEGSWAP_STATS_EN
          s_mode_d = swap_mode_e'(in_mode);
`endif
        end else if (drain) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          state_d  = OCC_ONE;
          m_data_d = s_data_q;
`ifdef SEGSWAP_STATS_EN
          m_mode_d = s_mode_q;
`endif
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    in_ready_d = (state_d != OCC_TWO);
  end

`ifdef SEGSWAP_STATS_EN
  always_comb begin
    cnt_d = cnt_q;
    if (drain && (m_mode_q != MODE_PASS) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end
`endif

  // Register stage: M/S storage and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      s_data_q   <= '0;
`ifdef SEGSWAP_STATS_EN
      m_mode_q   <= MODE_PASS;
      s_mode_q   <= MODE_PASS;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
`ifdef SEGSWAP_STATS_EN
      m_mode_q   <= m_mode_d;
      s_mode_q   <= s_mode_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_segment_swapper.sv
module tb_segment_swapper;

  localparam int DATA_W = 32;
  localparam int SEG_W  = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef SEGSWAP_STATS_EN
  logic [CNT_W-1:0]  swap_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segment_swapper #(.DATA_W(DATA_W), .SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SEGSWAP_STATS_EN
    ,
    .swap_count(swap_count)
`endif
  );

  typedef struct {
    logic [31:0] din;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h12345678, 2'b00, 32'h12345678};
    vecs[1] = '{32'h12345678, 2'b01, 32'h21436587};
    vecs[2] = '{32'h12345678, 2'b10, 32'h87654321};
    vecs[3] = '{32'h00000001, 2'b11, 32'h80000000};
    vecs[4] = '{32'h12345678, 2'b11, 32'h1E6A2C48};
    vecs[5] = '{32'hDEADBEEF, 2'b01, 32'hEDDAEBFE};
    vecs[6] = '{32'hDEADBEEF, 2'b10, 32'hFEEBDAED};
    vecs[7] = '{32'hFFFF0000, 2'b11, 32'h0000FFFF};
    vecs[8] = '{32'hA5A5A5A5, 2'b01, 32'h5A5A5A5A};
    vecs[9] = '{32'h0F0F0F0F, 2'b10, 32'hF0F0F0F0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b1;
    repeat (2) step();
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_data", out_data, 32'h0);
    rst_n = 1'b1;

    // Back-to-back stream: each beat must be on out_data one edge after acceptance
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      in_mode  = vecs[i].mode;
      step();
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Backpressure: two beats fill M and S, third is held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_mode = 2'b01;
    step();
    check("bp_first_data", out_data, 32'h5A5A5A5A);
    check("bp_first_ready", {31'b0, in_ready}, 32'd1);
    in_data = 32'h0F0F0F0F; in_mode = 2'b10;
    step();
    check("bp_full_ready", {31'b0, in_ready}, 32'd0);
    check("bp_full_data", out_data, 32'h5A5A5A5A);
    in_data = 32'h12345678; in_mode = 2'b10;
    step();
    check("bp_held_ready", {31'b0, in_ready}, 32'd0);
    check("bp_held_data", out_data, 32'h5A5A5A5A);
    out_ready = 1'b1;
    step();
    check("bp_out2_data", out_data, 32'hF0F0F0F0);
    check("bp_out2_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_out3_data", out_data, 32'h87654321);
    check("bp_out3_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Stability: idle input toggling must not disturb a stalled output
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_mode = 2'b01;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h11111111 * (i + 1);
      in_mode = 2'(i);
      step();
      check($sformatf("stable%0d_data", i), out_data, 32'hEDDAEBFE);
      check($sformatf("stable%0d_valid", i), {31'b0, out_valid}, 32'd1);
    end

    // Reset while in TWO discards both beats
    in_valid = 1'b1; in_data = 32'h12345678; in_mode = 2'b00;
    step();
    check("pre_rst_full", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_data", out_data, 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst%0d_valid", i), {31'b0, out_valid}, 32'd0);
    end

`ifdef SEGSWAP_STATS_EN
    begin
      logic [1:0] smodes[5];
      logic [1:0] sexp[5];
      smodes = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
      sexp   = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("stats_reset", {30'b0, swap_count}, 32'd0);
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; in_data = 32'hCAFE0000 + i; in_mode = smodes[i];
        step();
        in_valid = 1'b0;
        step();
        check($sformatf("stats%0d", i), {30'b0, swap_count}, {30'b0, sexp[i]});
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
